// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 tile spawner: board layout, spawner FSM states,
// and the 16-bit Galois LFSR step (x^16+x^14+x^13+x^11+1).
package game_2048_pkg;
  localparam int TILE_W = 12;
  localparam int GRID_N = 4;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [GRID_N-1:0][GRID_N-1:0] board_t;

  typedef enum logic [1:0] {SP_IDLE, SP_SCAN, SP_DONE} spawn_state_t;

  // Right-shifting Galois form: feedback bit is the LSB shifted out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction
endpackage

// File: rtl/tile_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock so user timing feeds the randomness.
module lfsr16
  import game_2048_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  // An all-zero state would lock the register, so a zero seed falls back to 1.
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= INIT;
    else      q <= lfsr_next(q);
  end
endmodule

// File: rtl/tile_spawner.sv
// Places one new tile (2, or 4 when TILE_SPAWN_FOUR_EN is defined) into a pseudo-random empty
// cell of the resolved 4x4 board, probing linearly from an LFSR-chosen start cell.
module tile_spawner
  import game_2048_pkg::*;
#(
  parameter int          DATA_W    = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          FOUR_BITS = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [GRID_N-1:0][GRID_N-1:0][DATA_W-1:0]   matrix,
  output logic [GRID_N-1:0][GRID_N-1:0][DATA_W-1:0]   matrix_out,
  output logic                                        done,
  output logic                                        full,
  output logic                                        busy
);
  spawn_state_t state;
  logic [GRID_N-1:0][GRID_N-1:0][DATA_W-1:0] matrix_q;
  logic [3:0]        pos;
  logic [3:0]        probe_cnt;
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] spawn_val;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

`ifdef TILE_SPAWN_FOUR_EN
  assign spawn_val = (&lfsr[15:16-FOUR_BITS]) ? DATA_W'(4) : DATA_W'(2);
`else
  // Upper LFSR bits only choose the tile value when 4-tiles are enabled.
  logic unused_lfsr;
  assign unused_lfsr = ^{lfsr[15:4], &lfsr[15:16-FOUR_BITS]};
  assign spawn_val   = DATA_W'(2);
`endif

  assign matrix_out = matrix_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SP_IDLE;
      matrix_q  <= '0;
      pos       <= '0;
      probe_cnt <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SP_IDLE: begin
          if (start) begin
            matrix_q  <= matrix;
            pos       <= lfsr[3:0];
            probe_cnt <= '0;
            full      <= 1'b0;
            busy      <= 1'b1;
            state     <= SP_SCAN;
          end
        end
        SP_SCAN: begin
          // One probe per clock; pos wraps naturally at 4 bits.
          if (matrix_q[pos[3:2]][pos[1:0]] == '0) begin
            matrix_q[pos[3:2]][pos[1:0]] <= spawn_val;
            done  <= 1'b1;
            state <= SP_DONE;
          end else if (probe_cnt == 4'd15) begin
            full  <= 1'b1;
            done  <= 1'b1;
            state <= SP_DONE;
          end else begin
            pos       <= pos + 4'd1;
            probe_cnt <= probe_cnt + 4'd1;
          end
        end
        SP_DONE: begin
          busy  <= 1'b0;
          state <= SP_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= SP_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tile_spawner.sv
// Directed scoreboard bench for tile_spawner: predicts placement, value, probe count and full flag
// from an independent LFSR model, then compares when done pulses.
module tb_tile_spawner;
  import game_2048_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   start = 1'b0;
  board_t matrix = '0;
  board_t matrix_out;
  logic   done, full, busy;

  tile_spawner #(.DATA_W(TILE_W), .LFSR_SEED(SEED), .FOUR_BITS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .matrix     (matrix),
    .matrix_out (matrix_out),
    .done       (done),
    .full       (full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= galois(m_lfsr);
  end

  typedef struct {
    board_t b;
    logic   f;
    int     n;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   fours    = 0;

  function automatic tile_t spawn_of(input logic [15:0] l);
`ifdef TILE_SPAWN_FOUR_EN
    return (&l[15:13]) ? tile_t'(4) : tile_t'(2);
`else
    return (l == 16'h0000) ? tile_t'(0) : tile_t'(2);
`endif
  endfunction

  // l0 is the LFSR value in the cycle whose closing edge accepts start.
  function automatic exp_t predict(input board_t b, input logic [15:0] l0);
    exp_t        e;
    logic [15:0] l;
    logic [3:0]  p;
    l = l0; p = l0[3:0];
    e.b = b; e.f = 1'b1; e.n = 16;
    for (int k = 0; k < 16; k++) begin
      l = galois(l);
      if (b[p[3:2]][p[1:0]] == '0) begin
        e.b[p[3:2]][p[1:0]] = spawn_of(l);
        e.f = 1'b0;
        e.n = k + 1;
        break;
      end
      p = p + 4'd1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input int n);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("matrix_out", matrix_out, e.b);
    chk("full", full, e.f);
    chk("probes", n, e.n);
  endtask

  // Call at a negedge while the DUT is idle; returns at the negedge of the done cycle.
  task automatic spawn(input board_t b);
    int k;
    bit seen;
    matrix = b;
    start  = 1'b1;
    sb.push_back(predict(b, m_lfsr));
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("full_cleared", full, 0);
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      chk("busy_during_op", busy, 1);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    if (seen) check_out(k - 1);
  endtask

  initial begin
    board_t      b;
    exp_t        e;
    int          k, dones, nz;
    bit          found;
    logic [3:0]  p0;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    chk("rst_matrix", matrix_out, '0);
    @(negedge clk); rst = 1'b1;

    // Empty board: one probe, exactly one tile
    @(negedge clk);
    spawn('0);
    nz = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (matrix_out[r][c] != '0) nz++;
    chk("empty_one_tile", nz, 1);

    // Only cell 13 empty, start lined up so the first probe is cell 14: wraps through 16 probes
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = tile_t'(8);
    b[3][1] = '0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_lfsr[3:0] == 4'd14) found = 1;
    end
    chk("lfsr_align", found, 1);
    if (found) begin
      spawn(b);
`ifndef TILE_SPAWN_FOUR_EN
      chk("wrap_cell13", matrix_out[3][1], 12'd2);
`endif
      chk("wrap_not_full", full, 0);
    end

    // Full board: 16 probes, full set, board untouched; full sticky until next start
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = tile_t'(8);
    @(negedge clk);
    spawn(b);
    chk("full_board_same", matrix_out, b);
    @(negedge clk);
    chk("full_sticky", full, 1);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    spawn('0);
    chk("full_after_restart", full, 0);

    // Extra start pulses during SCAN are ignored
    @(negedge clk);
    p0 = m_lfsr[3:0] + 4'd10;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = tile_t'(16);
    b[p0[3:2]][p0[1:0]] = '0;
    matrix = b;
    start  = 1'b1;
    sb.push_back(predict(b, m_lfsr));
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 4 || k == 6);
      if (dones == 0) chk("busy_scan", busy, 1);
      if (done) begin
        dones++;
        if (dones == 1) check_out(k - 1);
      end
    end
    start = 1'b0;
    chk("single_done", dones, 1);
    chk("restart_ignored_busy", busy, 0);

    // Reset mid-SCAN
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = tile_t'(8);
    @(negedge clk);
    matrix = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("midscan_rst_busy", busy, 0);
    chk("midscan_rst_matrix", matrix_out, '0);
    chk("midscan_rst_done", done, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    spawn('0);

    // Distribution of spawned values on empty boards
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      spawn('0);
      nz = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (matrix_out[r][c] == tile_t'(4)) fours++;
          if (matrix_out[r][c] != '0 && matrix_out[r][c] != tile_t'(2) &&
              matrix_out[r][c] != tile_t'(4)) nz++;
        end
      if (nz != 0) chk("tile_value_legal", nz, 0);
    end
`ifdef TILE_SPAWN_FOUR_EN
    chk("fours_in_range", (fours >= 435 && fours <= 589), 1);
`else
    chk("no_fours", fours, 0);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
